// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC owner, 1-cycle registered imem read, 2-entry {pc,instr} buffer
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nreset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  logic [31:0] fetch_pc_q,   fetch_pc_d;
  logic        pending_q,    pending_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [1:0]  count_q,      count_d;
  logic [31:0] pc0_q,    pc0_d;
  logic [31:0] instr0_q, instr0_d;
  logic [31:0] pc1_q,    pc1_d;
  logic [31:0] instr1_q, instr1_d;

  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic [2:0] w_occ;

  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = pc0_q;
  assign out_instr = instr0_q;

  // Slot 0 is always the head; slot 1 shifts down on pop.
  always_comb begin
    w_pop   = out_valid && out_ready;
    w_push  = pending_q && !redirect_valid;
    w_occ   = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, w_pop};
    w_issue = !redirect_valid && (w_occ < 3'd2);

    fetch_pc_d   = fetch_pc_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
    count_d      = count_q;
    pc0_d        = pc0_q;
    instr0_d     = instr0_q;
    pc1_d        = pc1_q;
    instr1_d     = instr1_q;

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      pending_d  = 1'b0;
      count_d    = 2'd0;
    end else begin
      pending_d = w_issue;
      if (w_issue) begin
        pending_pc_d = fetch_pc_q;
        fetch_pc_d   = fetch_pc_q + 32'd4;
      end
      case ({w_push, w_pop})
        2'b11: begin
          if (count_q == 2'd2) begin
            pc0_d    = pc1_q;
            instr0_d = instr1_q;
            pc1_d    = pending_pc_q;
            instr1_d = imem_rdata;
          end else begin
            pc0_d    = pending_pc_q;
            instr0_d = imem_rdata;
          end
        end
        2'b01: begin
          pc0_d    = pc1_q;
          instr0_d = instr1_q;
          count_d  = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            pc0_d    = pending_pc_q;
            instr0_d = imem_rdata;
          end else begin
            pc1_d    = pending_pc_q;
            instr1_d = imem_rdata;
          end
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      fetch_pc_q   <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= 32'd0;
      count_q      <= 2'd0;
      pc0_q        <= 32'd0;
      instr0_q     <= 32'd0;
      pc1_q        <= 32'd0;
      instr1_q     <= 32'd0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      pc0_q        <= pc0_d;
      instr0_q     <= instr0_d;
      pc1_q        <= pc1_d;
      instr1_q     <= instr1_d;
    end
  end

endmodule

`default_nettype wire
